trackball_in_cond: RTL and testbench
====================================

# trackball_in_cond

Input conditioner that sits directly upstream of the trackball decoder. It takes the four raw trackball lines from the JA header (horizontal direction, horizontal clock, vertical direction, vertical clock), synchronises them to `clk` and rejects short glitches. It presents clean levels to the trackball decoder, plus one-cycle step pulses with latched direction and a saturating glitch counter for board bring-up.

## Interface
Parameters:
- `SAMPLE_DIV`, default 100: clocks per filter sample tick; legal range ≥1.
- `FILT_LEN`, default 4: consecutive differing ticks needed to accept a new level; legal range ≥2.

Ports:
- `clk` input 1: single system clock; all logic on its rising edge.
- `rst_l` input 1: reset, synchronous and active-low.
- `raw` input 4: unsynchronised pins, with bits {verclk, verdir, horclk, hordir} = [3:0].
- `filt` output 4: filtered levels, same bit order; these drive the trackball decoder inputs.
- `hor_step` output 1: one-cycle pulse on each accepted horclk rise.
- `hor_up` output 1: filtered hordir captured at the last `hor_step`.
- `ver_step` output 1: one-cycle pulse on each accepted verclk rise.
- `ver_up` output 1: filtered verdir captured at the last `ver_step`.
- `ready` output 1: high once post-reset settling is complete.
- `glitch_cnt` output 8: count of rejected transitions, saturating.

## Operation
- **Synchroniser:** a 2-FF chain per bit, `sync1` then `sync2`; reset value 0.
- **Tick counter:** counts 0..SAMPLE_DIV-1 and wraps to 0.
  - `tick` is high in the cycle where count == SAMPLE_DIV-1.
  - With SAMPLE_DIV=1, `tick` is high every cycle.
- **Per-bit filter:** each bit has a run counter `run`, width clog2(FILT_LEN). The following applies on `tick` only:
  - If `sync2` == `filt`: `run` is set to 0. If `run` was nonzero, this is an aborted transition.
  - If `sync2` != `filt` and `run` == FILT_LEN-1: `filt` takes `sync2` and `run` is set to 0.
  - If `sync2` != `filt` otherwise: `run` increments by 1.
- **Glitch counter:** `glitch_cnt` increments by 1 in any tick where at least one bit aborts.
  - Several bits aborting in the same tick still count as a single increment.
  - The counter holds at 255 and never wraps.
- **Ready / arm:** a settle counter counts ticks after reset. `ready` is set when FILT_LEN+2 ticks have elapsed and stays high until the next reset.
  - Filtering runs normally while `ready` is low; only step pulses are suppressed.
- **Step detection:** `filt_q` is a one-cycle delayed copy of `filt`.
  - `hor_step` = registered (`filt`[1] & ~`filt_q`[1] & `ready`).
  - `hor_up` is loaded with `filt`[0] in the same cycle the pulse is registered, and holds otherwise.
  - `ver_step` and `ver_up` work the same way on bits [3] and [2].
  - Falling edges produce no pulse.
- **Reset values:** all outputs are 0, including `filt`, both steps, both up flags, `ready` and `glitch_cnt`. All internal counters and registers are also 0.

## Timing
Latency below assumes SAMPLE_DIV=1 and FILT_LEN=4, with `raw` changing before edge 0:
- `sync2` shows the new value after edge 1.
- The filter ticks at edges 2, 3 and 4 (run = 1, 2, 3); `filt` updates at edge 5.
- `hor_step` is high for exactly one cycle after edge 6, and `hor_up` is valid from edge 6.

General latency from `raw` change to `filt` is 2 + FILT_LEN×SAMPLE_DIV cycles, with up to SAMPLE_DIV-1 extra cycles of tick phase. Step outputs follow `filt` by 1 cycle.

Boundary conditions:
- **Minimum pulse width:** a raw pulse shorter than FILT_LEN ticks never reaches `filt`. An input held for exactly FILT_LEN ticks is accepted.
- **Reset mid-operation:** `rst_l` low at any edge forces every register to its reset value at that edge, overriding any `tick` in the same cycle. `ready` drops to 0 and the settle count restarts.
- **Idle-high lines at power-up:** `filt` rises during settling but emits no step, because `ready` is still low.

## Test plan
All scenarios use SAMPLE_DIV=1 and FILT_LEN=4 unless stated otherwise.
- **Reset:** hold `rst_l`=0 for 3 cycles with `raw`=4'hF -> all outputs 0. After release, `ready` rises after tick 6, `filt`=4'hF, and no `hor_step` or `ver_step` is seen.
- **Clean horizontal step:** after `ready`, set `raw`[0]=1, then `raw`[1] 0→1 for 10 cycles -> exactly one `hor_step`, 7 cycles after the `raw`[1] edge, with `hor_up`=1. The falling edge gives no pulse.
- **Glitch rejection:** pulse `raw`[3] high for 3 cycles -> `filt`[3] stays 0, no `ver_step`, `glitch_cnt` goes 0→1. A 4-cycle pulse is accepted and `glitch_cnt` is unchanged.
- **Simultaneous aborts and saturation:** 3-cycle pulses on `raw`[1] and `raw`[3] together -> `glitch_cnt` +1 only. Repeat 300 times -> `glitch_cnt`=255.
- **Divider:** SAMPLE_DIV=5, FILT_LEN=4, hold a `raw`[1] rise -> `filt`[1] changes between 22 and 26 cycles after the edge. A 15-cycle pulse is rejected.
- **Mid-operation reset:** assert `rst_l`=0 while `run`=2 on bit 1 -> the next cycle shows all registers 0 and `ready`=0, and the pending transition is discarded.

Source files
------------

// File: rtl/trackball_in_cond.sv
// Trackball input conditioner: synchronises the four raw trackball lines, filters
// out short glitches, and produces step pulses, latched direction and a glitch count.
module trackball_in_cond #(
    parameter int SAMPLE_DIV = 100,
    parameter int FILT_LEN   = 4
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic [3:0] raw,
    output logic [3:0] filt,
    output logic       hor_step,
    output logic       hor_up,
    output logic       ver_step,
    output logic       ver_up,
    output logic       ready,
    output logic [7:0] glitch_cnt
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int RW = $clog2(FILT_LEN);
    localparam int SW = $clog2(FILT_LEN + 3);
    localparam logic [CW-1:0] DIV_LAST    = CW'(SAMPLE_DIV - 1);
    localparam logic [RW-1:0] RUN_LAST    = RW'(FILT_LEN - 1);
    localparam logic [SW-1:0] SETTLE_DONE = SW'(FILT_LEN + 2);

    logic [3:0]         sync1_r;
    logic [3:0]         sync2_r;
    logic [CW-1:0]      cnt_r;
    logic               tick_s;
    logic [3:0][RW-1:0] run_r;
    logic [3:0][RW-1:0] run_nxt_s;
    logic [3:0]         filt_nxt_s;
    logic               abort_s;
    logic [SW-1:0]      settle_r;
    logic [3:0]         filt_q_r;
    logic               hor_rise_s;
    logic               ver_rise_s;

    assign tick_s     = (cnt_r == DIV_LAST);
    assign hor_rise_s = filt[1] & ~filt_q_r[1] & ready;
    assign ver_rise_s = filt[3] & ~filt_q_r[3] & ready;

    // Per-bit run-length filter evaluated on each sample tick.
    always_comb begin
        run_nxt_s  = run_r;
        filt_nxt_s = filt;
        abort_s    = 1'b0;
        if (tick_s) begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == filt[i]) begin
                    run_nxt_s[i] = {RW{1'b0}};
                    if (run_r[i] != {RW{1'b0}}) begin
                        abort_s = 1'b1;
                    end else begin
                        abort_s = abort_s;
                    end
                end else if (run_r[i] == RUN_LAST) begin
                    filt_nxt_s[i] = sync2_r[i];
                    run_nxt_s[i]  = {RW{1'b0}};
                end else begin
                    run_nxt_s[i] = run_r[i] + RW'(1);
                end
            end
        end else begin
            run_nxt_s = run_r;
        end
    end

    // Synchroniser, tick divider, filter state, glitch and settle counters.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            sync1_r    <= 4'h0;
            sync2_r    <= 4'h0;
            cnt_r      <= {CW{1'b0}};
            run_r      <= '0;
            filt       <= 4'h0;
            glitch_cnt <= 8'd0;
            settle_r   <= {SW{1'b0}};
            ready      <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            cnt_r   <= tick_s ? {CW{1'b0}} : cnt_r + CW'(1);
            run_r   <= run_nxt_s;
            filt    <= filt_nxt_s;
            if (tick_s && abort_s && (glitch_cnt != 8'hFF)) begin
                glitch_cnt <= glitch_cnt + 8'd1;
            end else begin
                glitch_cnt <= glitch_cnt;
            end
            if (tick_s && (settle_r != SETTLE_DONE)) begin
                settle_r <= settle_r + SW'(1);
            end else begin
                settle_r <= settle_r;
            end
            ready <= ready | (settle_r == SETTLE_DONE);
        end
    end

    // Rising-edge step pulses with direction captured alongside each pulse.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            filt_q_r <= 4'h0;
            hor_step <= 1'b0;
            hor_up   <= 1'b0;
            ver_step <= 1'b0;
            ver_up   <= 1'b0;
        end else begin
            filt_q_r <= filt;
            hor_step <= hor_rise_s;
            ver_step <= ver_rise_s;
            hor_up   <= hor_rise_s ? filt[0] : hor_up;
            ver_up   <= ver_rise_s ? filt[2] : ver_up;
        end
    end

endmodule

// File: tb/tb_trackball_in_cond.sv
// Directed bench for trackball_in_cond: step events go through a scoreboard queue,
// level/counter outputs are compared directly against hand-computed values.
module tb_trackball_in_cond;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [3:0] raw;
    logic [3:0] filt;
    logic       hor_step, hor_up, ver_step, ver_up, ready;
    logic [7:0] glitch_cnt;

    logic       rst2;
    logic [3:0] raw2;
    logic [3:0] filt2;
    logic       hor_step2, hor_up2, ver_step2, ver_up2, ready2;
    logic [7:0] glitch_cnt2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit ver;
        bit up;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    trackball_in_cond #(.SAMPLE_DIV(1), .FILT_LEN(4)) dut (
        .clk(clk), .rst_l(rst_l), .raw(raw), .filt(filt),
        .hor_step(hor_step), .hor_up(hor_up), .ver_step(ver_step), .ver_up(ver_up),
        .ready(ready), .glitch_cnt(glitch_cnt)
    );

    trackball_in_cond #(.SAMPLE_DIV(5), .FILT_LEN(4)) dut_div (
        .clk(clk), .rst_l(rst2), .raw(raw2), .filt(filt2),
        .hor_step(hor_step2), .hor_up(hor_up2), .ver_step(ver_step2), .ver_up(ver_up2),
        .ready(ready2), .glitch_cnt(glitch_cnt2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic take_step(input bit is_ver, input logic up);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_step: got ver=%0d at cycle %0d want none", is_ver, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("step_kind", {31'd0, is_ver}, {31'd0, e.ver});
            chk("step_cycle", cyc, e.cyc);
            chk("step_up", {31'd0, up}, {31'd0, e.up});
        end
    endtask

    // Scoreboard monitor: every step pulse must match the head of the queue.
    always @(negedge clk) begin
        if (hor_step === 1'b1) take_step(1'b0, hor_up);
        if (ver_step === 1'b1) take_step(1'b1, ver_up);
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_step(input bit is_ver, input bit up);
        exp_t e;
        e.ver = is_ver;
        e.up  = up;
        e.cyc = cyc + 7;
        exp_q.push_back(e);
    endtask

    task automatic pulse_watch(input logic [3:0] mask, input int len, input int idle,
                               output logic seen);
        seen = 1'b0;
        raw  = raw | mask;
        for (int i = 0; i < len + idle; i++) begin
            @(negedge clk);
            if ((filt & mask) != 4'h0) seen = 1'b1;
            if (i == len - 1) raw = raw & ~mask;
        end
    endtask

    initial begin
        logic seen;
        int   n;
        logic hold_ok;

        rst_l = 1'b0;
        raw   = 4'hF;
        rst2  = 1'b0;
        raw2  = 4'h0;

        // Reset with idle-high lines
        wait_neg(3);
        chk("rst_filt", {28'd0, filt}, 32'h0);
        chk("rst_steps", {30'd0, hor_step, ver_step}, 32'h0);
        chk("rst_up", {30'd0, hor_up, ver_up}, 32'h0);
        chk("rst_ready", {31'd0, ready}, 32'h0);
        chk("rst_glitch", {24'd0, glitch_cnt}, 32'h0);
        rst_l = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("settle_ready_low", {31'd0, ready}, 32'h0);
        repeat (7) @(posedge clk);
        #1 chk("settle_ready_high", {31'd0, ready}, 32'h1);
        chk("settle_filt", {28'd0, filt}, 32'hF);

        // Clean horizontal step
        @(negedge clk);
        raw = 4'h0;
        wait_neg(10);
        chk("idle_filt", {28'd0, filt}, 32'h0);
        raw = 4'h1;
        wait_neg(10);
        raw = 4'h3;
        push_step(1'b0, 1'b1);
        wait_neg(10);
        raw = 4'h1;
        wait_neg(12);
        chk("hor_filt_after", {28'd0, filt}, 32'h1);
        chk("hor_up_hold", {31'd0, hor_up}, 32'h1);

        // Glitch rejection: 3 ticks rejected, 4 ticks accepted
        pulse_watch(4'h8, 3, 10, seen);
        chk("glitch3_filt_seen", {31'd0, seen}, 32'h0);
        chk("glitch3_cnt", {24'd0, glitch_cnt}, 32'd1);
        push_step(1'b1, 1'b0);
        pulse_watch(4'h8, 4, 12, seen);
        chk("pulse4_filt_seen", {31'd0, seen}, 32'h1);
        chk("pulse4_cnt", {24'd0, glitch_cnt}, 32'd1);

        // Simultaneous aborts count once, then saturation
        pulse_watch(4'hA, 3, 8, seen);
        chk("dual_abort_cnt", {24'd0, glitch_cnt}, 32'd2);
        chk("dual_abort_seen", {31'd0, seen}, 32'h0);
        for (int k = 0; k < 300; k++) pulse_watch(4'hA, 3, 5, seen);
        chk("glitch_sat", {24'd0, glitch_cnt}, 32'd255);

        // Mid-operation reset while bit 1 has run=2
        raw = 4'h3;
        wait_neg(4);
        rst_l = 1'b0;
        raw   = 4'h0;
        @(negedge clk);
        chk("midrst_filt", {28'd0, filt}, 32'h0);
        chk("midrst_ready", {31'd0, ready}, 32'h0);
        chk("midrst_glitch", {24'd0, glitch_cnt}, 32'h0);
        chk("midrst_up", {30'd0, hor_up, ver_up}, 32'h0);
        chk("midrst_steps", {30'd0, hor_step, ver_step}, 32'h0);
        rst_l = 1'b1;
        wait_neg(12);
        chk("postrst_filt", {28'd0, filt}, 32'h0);
        chk("postrst_ready", {31'd0, ready}, 32'h1);

        // Divider instance: SAMPLE_DIV=5, tick phase chosen for the 22-cycle case
        rst2 = 1'b1;
        wait_neg(8);
        raw2 = 4'h2;
        n = 0;
        while (n <= 40 && filt2[1] !== 1'b1) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("div_latency_in_window", {31'd0, (n >= 22 && n <= 26)}, 32'h1);
        chk("div_latency", n, 32'd22);
        @(negedge clk);
        raw2    = 4'h0;
        hold_ok = 1'b1;
        for (int i = 0; i < 45; i++) begin
            if (i == 15) raw2 = 4'h2;
            @(negedge clk);
            if (filt2[1] !== 1'b1) hold_ok = 1'b0;
        end
        chk("div_15_rejected", {31'd0, hold_ok}, 32'h1);
        chk("div_glitch", {24'd0, glitch_cnt2}, 32'd1);

        wait_neg(5);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
